// File: rtl/mesh_seq.sv
// mesh_seq: holds A/B/D operands for one 4x4 Mesh job, drives the skewed
// preload/compute edge streams and captures the skewed C outputs.
module mesh_seq #(
   parameter int DW       = 8,
   parameter int CW       = 16,
   parameter int MESH_LAT = 5
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [1:0]    wr_sel,
   input  logic [1:0]    wr_row,
   input  logic [1:0]    wr_col,
   input  logic [CW-1:0] wr_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [1:0]    rd_row,
   input  logic [1:0]    rd_col,
   output logic [CW-1:0] rd_data,
   output logic [DW-1:0] mesh_a_0,
   output logic [DW-1:0] mesh_a_1,
   output logic [DW-1:0] mesh_a_2,
   output logic [DW-1:0] mesh_a_3,
   output logic [DW-1:0] mesh_b_0,
   output logic [DW-1:0] mesh_b_1,
   output logic [DW-1:0] mesh_b_2,
   output logic [DW-1:0] mesh_b_3,
   output logic [CW-1:0] mesh_d_0,
   output logic [CW-1:0] mesh_d_1,
   output logic [CW-1:0] mesh_d_2,
   output logic [CW-1:0] mesh_d_3,
   output logic          mesh_prop_0,
   output logic          mesh_prop_1,
   output logic          mesh_prop_2,
   output logic          mesh_prop_3,
   input  logic [CW-1:0] mesh_c_0,
   input  logic [CW-1:0] mesh_c_1,
   input  logic [CW-1:0] mesh_c_2,
   input  logic [CW-1:0] mesh_c_3
);
   typedef enum logic [1:0] {IDLE, PRELOAD, COMPUTE, DRAIN} state_t;
   localparam logic [4:0] LAST = 5'(6 + MESH_LAT);
   state_t        state_q, state_d;
   logic [4:0]    t_q, t_d, k;
   logic [DW-1:0] a_q [4][4], a_d [4][4], b_q [4][4], b_d [4][4];
   logic [CW-1:0] d_q [4][4], d_d [4][4], c_q [4][4], c_d [4][4];
   logic [DW-1:0] ma_q [4], ma_d [4], mb_q [4], mb_d [4];
   logic [CW-1:0] md_q [4], md_d [4], mc [4];
   logic [3:0]    mp_q, mp_d;
   logic          busy_q, busy_d, done_q, done_d;
   assign mc[0] = mesh_c_0;
   assign mc[1] = mesh_c_1;
   assign mc[2] = mesh_c_2;
   assign mc[3] = mesh_c_3;
   always_comb begin
      state_d = state_q;
      t_d     = t_q + 5'd1;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      c_d     = c_q;
      done_d  = 1'b0;
      k       = '0;
      case (state_q)
         IDLE: begin
            t_d = '0;
            if (wr_en && wr_sel == 2'd0) a_d[wr_row][wr_col] = wr_data[DW-1:0];
            if (wr_en && wr_sel == 2'd1) b_d[wr_row][wr_col] = wr_data[DW-1:0];
            if (wr_en && wr_sel == 2'd2) d_d[wr_row][wr_col] = wr_data;
            if (start) state_d = PRELOAD;
         end
         PRELOAD: if (t_q == 5'd6) begin
            state_d = COMPUTE;
            t_d     = '0;
         end
         COMPUTE: if (t_q == 5'd6) state_d = DRAIN;
         default: if (t_q == LAST) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b1;
         end
      endcase
      // DRAIN keeps counting from COMPUTE, so one step count serves all captures
      for (int i = 0; i < 4; i++)
         for (int r = 0; r < 4; r++)
            if ((state_q == COMPUTE || state_q == DRAIN) && t_q == 5'(MESH_LAT + r + i))
               c_d[2'(r)][2'(i)] = mc[2'(i)];
      busy_d = state_d != IDLE;
      for (int i = 0; i < 4; i++) begin
         k              = t_d - 5'(i);
         mp_d[2'(i)]    = state_d == PRELOAD && k < 5'd4;
         md_d[2'(i)]    = mp_d[2'(i)] ? d_d[k[1:0]][2'(i)] : '0;
         ma_d[2'(i)]    = (state_d == COMPUTE && k < 5'd4) ? a_d[k[1:0]][2'(i)] : '0;
         mb_d[2'(i)]    = (state_d == COMPUTE && k < 5'd4) ? b_d[k[1:0]][2'(i)] : '0;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= '0;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         d_q     <= '{default: '0};
         c_q     <= '{default: '0};
         ma_q    <= '{default: '0};
         mb_q    <= '{default: '0};
         md_q    <= '{default: '0};
         mp_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         c_q     <= c_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         md_q    <= md_d;
         mp_q    <= mp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_data     = c_q[rd_row][rd_col];
   assign mesh_a_0    = ma_q[0];
   assign mesh_a_1    = ma_q[1];
   assign mesh_a_2    = ma_q[2];
   assign mesh_a_3    = ma_q[3];
   assign mesh_b_0    = mb_q[0];
   assign mesh_b_1    = mb_q[1];
   assign mesh_b_2    = mb_q[2];
   assign mesh_b_3    = mb_q[3];
   assign mesh_d_0    = md_q[0];
   assign mesh_d_1    = md_q[1];
   assign mesh_d_2    = md_q[2];
   assign mesh_d_3    = md_q[3];
   assign mesh_prop_0 = mp_q[0];
   assign mesh_prop_1 = mp_q[1];
   assign mesh_prop_2 = mp_q[2];
   assign mesh_prop_3 = mp_q[3];
endmodule

// File: tb/tb_mesh_seq.sv
// tb_mesh_seq: three sequencers (MESH_LAT 5, 1, 15) run in lockstep against
// a cycle-level Mesh model driven by directed operand sets.
module tb_mesh_seq;
   logic        clock = 1'b0, reset = 1'b0, wr_en = 1'b0, start = 1'b0;
   logic [1:0]  wr_sel = '0, wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
   logic [15:0] wr_data = '0;
   logic        busy [3], done [3];
   logic [15:0] rd_data [3];
   logic [7:0]  ma [3][4], mb [3][4];
   logic [15:0] md [3][4], mc [3][4];
   logic        mp [3][4];
   logic [7:0]  ta [4][4], tbm [4][4];
   logic [15:0] td [4][4];
   logic [15:0] dtab [7] = '{16'h0, 16'h0, 16'h02, 16'h12, 16'h22, 16'h32, 16'h0};
   int          n_chk = 0, n_pass = 0;
   always #5 clock = ~clock;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mesh_seq #(.MESH_LAT(g == 0 ? 5 : g == 1 ? 1 : 15)) dut (
         .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
         .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
         .busy(busy[g]), .done(done[g]), .rd_row(rd_row), .rd_col(rd_col),
         .rd_data(rd_data[g]),
         .mesh_a_0(ma[g][0]), .mesh_a_1(ma[g][1]), .mesh_a_2(ma[g][2]), .mesh_a_3(ma[g][3]),
         .mesh_b_0(mb[g][0]), .mesh_b_1(mb[g][1]), .mesh_b_2(mb[g][2]), .mesh_b_3(mb[g][3]),
         .mesh_d_0(md[g][0]), .mesh_d_1(md[g][1]), .mesh_d_2(md[g][2]), .mesh_d_3(md[g][3]),
         .mesh_prop_0(mp[g][0]), .mesh_prop_1(mp[g][1]), .mesh_prop_2(mp[g][2]), .mesh_prop_3(mp[g][3]),
         .mesh_c_0(mc[g][0]), .mesh_c_1(mc[g][1]), .mesh_c_2(mc[g][2]), .mesh_c_3(mc[g][3])
      );
   end
   function automatic int lat(int g);
      return g == 0 ? 5 : g == 1 ? 1 : 15;
   endfunction
   task automatic chk(string tag, logic [131:0] got, logic [131:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   function automatic logic [15:0] prod(int r, int j);
      logic [15:0] s = td[r][j];
      for (int k = 0; k < 4; k++) s = s + ta[r][k] * tbm[k][j];
      return s;
   endfunction
   function automatic logic [131:0] lanes_obs(int g);
      logic [131:0] o = '0;
      for (int j = 0; j < 4; j++) begin
         o[8*j +: 8]       = ma[g][j];
         o[32+8*j +: 8]    = mb[g][j];
         o[64+16*j +: 16]  = md[g][j];
         o[128+j]          = mp[g][j];
      end
      return o;
   endfunction
   // expected edge streams for cycle n after the start edge, independent of MESH_LAT
   function automatic logic [131:0] lanes_exp(int n);
      logic [131:0] e = '0;
      int k;
      for (int j = 0; j < 4; j++) begin
         if (n >= 1 && n <= 7) begin
            k = n - 1 - j;
            if (k >= 0 && k <= 3) begin
               e[64+16*j +: 16] = td[k][j];
               e[128+j]         = 1'b1;
            end
         end else if (n >= 8 && n <= 14) begin
            k = n - 8 - j;
            if (k >= 0 && k <= 3) begin
               e[8*j +: 8]    = ta[k][j];
               e[32+8*j +: 8] = tbm[k][j];
            end
         end
      end
      return e;
   endfunction
   task automatic wr(input logic [1:0] sel, input int r, input int c, input logic [15:0] v);
      wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = v;
      @(posedge clock); #1;
      wr_en = 1'b0;
   endtask
   task automatic load();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            wr(2'd0, r, c, {8'h0, ta[r][c]});
            wr(2'd1, r, c, {8'h0, tbm[r][c]});
            wr(2'd2, r, c, td[r][c]);
         end
   endtask
   task automatic ident();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ta[r][c] = 8'(r == c); tbm[r][c] = 8'(r == c); td[r][c] = '0;
         end
   endtask
   // mode 0: product model, mode 1: stub returning {t, j}
   task automatic run_job(input int mode, input bit skew, input bit stir);
      int r;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int n = 1; n <= 31; n++) begin
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("lanes_i%0d_c%0d", g, n), lanes_obs(g), lanes_exp(n));
            chk($sformatf("busy_done_i%0d_c%0d", g, n), {busy[g], done[g]},
                {n < 15 + lat(g), n == 15 + lat(g)});
            for (int j = 0; j < 4; j++) begin
               r = n - 8 - lat(g) - j;
               mc[g][j] = mode == 1 ? {8'(n - 8), 8'(j)} : (r >= 0 && r <= 3) ? prod(r, j) : 16'hBAD0;
            end
         end
         if (skew && n <= 7) begin
            chk($sformatf("d2_skew_t%0d", n - 1), md[0][2], dtab[n-1]);
            chk($sformatf("prop2_skew_t%0d", n - 1), mp[0][2], n >= 3 && n <= 6);
         end
         if (stir) begin
            start = n == 5;
            wr_en = n == 10; wr_sel = 2'd0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 16'h7F;
         end
         @(posedge clock); #1;
      end
      start = 1'b0; wr_en = 1'b0;
   endtask
   // mode 0: product, 1: stub alignment, 2: cleared
   task automatic readback(input int mode);
      logic [15:0] e;
      for (int g = 0; g < 3; g++)
         for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
               rd_row = 2'(r); rd_col = 2'(j);
               #1;
               e = mode == 2 ? 16'h0 : mode == 1 ? {8'(lat(g) + r + j), 8'(j)} : prod(r, j);
               chk($sformatf("c_i%0d_r%0d_c%0d", g, r, j), rd_data[g], e);
            end
   endtask
   initial begin
      for (int g = 0; g < 3; g++)
         for (int j = 0; j < 4; j++) mc[g][j] = '0;
      reset = 1'b1;
      #12;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_lanes_i%0d", g), lanes_obs(g), '0);
         chk($sformatf("rst_busy_done_i%0d", g), {busy[g], done[g]}, '0);
         chk($sformatf("rst_c_i%0d", g), rd_data[g], '0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      ident(); load(); run_job(0, 0, 0); readback(0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ta[r][c] = 8'(4 * r + c + 1); tbm[r][c] = 8'(2 * r + c); td[r][c] = 16'(16 * r + c);
         end
      load(); run_job(0, 1, 0); readback(0);
      run_job(1, 0, 0); readback(1);
      ident(); load(); run_job(0, 0, 1); readback(0);
      run_job(0, 0, 0); readback(0);
      start = 1'b1;
      @(posedge clock); #1;
      for (int n = 1; n <= 45; n++) begin
         chk($sformatf("hold_busy_done_c%0d", n), {busy[0], done[0]},
             {(n < 20) || (n > 20 && n < 40), n == 20 || n == 40});
         if (n == 21) start = 1'b0;
         @(posedge clock); #1;
      end
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (11) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("abort_lanes_i%0d", g), lanes_obs(g), '0);
         chk($sformatf("abort_busy_done_i%0d", g), {busy[g], done[g]}, '0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int n = 0; n < 30; n++) begin
         for (int g = 0; g < 3; g++)
            chk($sformatf("post_abort_i%0d_c%0d", g, n), {busy[g], done[g]}, '0);
         @(posedge clock); #1;
      end
      readback(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
